// File: rtl/axis_cpu_loader.sv
// -----------------------------------------------------------------------------
// axis_cpu_loader
//   Programming front end for the streaming BPF-style CPU core. It parses a
//   32-bit AXI-Stream program image made of records and turns it into write
//   strobes for the instruction, immediate and jump-offset memories. The CPU
//   is held in reset while a load is in progress. When the packet ends, the
//   loader pulses done for a clean end or err for a malformed packet.
//
//   Record header: [31:30] target, [29:16] payload count, [15:0] start address.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   prog_TDATA      program stream data (32)
//   prog_TVALID     program stream valid
//   prog_TREADY     program stream ready (low only while rst is high)
//   prog_TLAST      last beat of the program packet
//   mem_wr_en       one-cycle write strobe per payload word (latency 1)
//   mem_wr_sel      target memory: 0 instr, 1 imm, 2 jmp_off
//   mem_wr_addr     write address (CODE_ADDR_WIDTH)
//   mem_wr_data     write data (32)
//   hold_in_rst     CPU held in reset while high
//   done / err      one-cycle end-of-packet status pulses
// -----------------------------------------------------------------------------
module axis_cpu_loader #(
   parameter int unsigned CODE_ADDR_WIDTH = 10,
   parameter int unsigned IMM_WIDTH       = 32,
   parameter int unsigned JMP_OFF_WIDTH   = CODE_ADDR_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                prog_TDATA,
   input  logic                       prog_TVALID,
   output logic                       prog_TREADY,
   input  logic                       prog_TLAST,
   output logic                       mem_wr_en,
   output logic [1:0]                 mem_wr_sel,
   output logic [CODE_ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [31:0]                mem_wr_data,
   output logic                       hold_in_rst,
   output logic                       done,
   output logic                       err
);

   // No sink reads data bits above its own width. Bits above the widest sink
   // are cleared. With the default IMM_WIDTH of 32 the data passes through
   // unchanged.
   localparam int unsigned SINK_W_A = (IMM_WIDTH > 8) ? IMM_WIDTH : 8;
   localparam int unsigned WIDEST   = (JMP_OFF_WIDTH > SINK_W_A) ? JMP_OFF_WIDTH : SINK_W_A;
   localparam logic [31:0] DATA_MASK = (WIDEST >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << WIDEST) - 32'd1);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAYLOAD,
      DRAIN
   } state_e;

   state_e                     state_q;
   logic [1:0]                 tgt_q;
   logic [CODE_ADDR_WIDTH-1:0] addr_q;
   logic [13:0]                rem_q;

   logic                       wr_en_q;
   logic [1:0]                 wr_sel_q;
   logic [CODE_ADDR_WIDTH-1:0] wr_addr_q;
   logic [31:0]                wr_data_q;
   logic                       hold_q;
   logic                       done_q;
   logic                       err_q;

   logic                       acc;
   logic [1:0]                 hdr_tgt;
   logic [13:0]                hdr_cnt;
   logic [CODE_ADDR_WIDTH-1:0] hdr_addr;

   // Writes never stall, so the only cycles that are not ready are reset cycles.
   assign prog_TREADY = ~rst;
   assign acc         = prog_TVALID & prog_TREADY;

   assign hdr_tgt  = prog_TDATA[31:30];
   assign hdr_cnt  = prog_TDATA[29:16];
   assign hdr_addr = prog_TDATA[CODE_ADDR_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tgt_q     <= '0;
         addr_q    <= '0;
         rem_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_sel_q  <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         hold_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         if (acc) begin
            case (state_q)
               IDLE, HDR: begin
                  // A header beat always raises hold. Ending the packet on the
                  // same beat clears it again through the later assignment.
                  hold_q <= 1'b1;
                  if (hdr_tgt == 2'd3) begin
                     if (prog_TLAST) begin
                        err_q   <= 1'b1;
                        hold_q  <= 1'b0;
                        state_q <= IDLE;
                     end else begin
                        state_q <= DRAIN;
                     end
                  end else if (hdr_cnt == '0) begin
                     if (prog_TLAST) begin
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                        state_q <= IDLE;
                     end else begin
                        state_q <= HDR;
                     end
                  end else if (prog_TLAST) begin
                     err_q   <= 1'b1;
                     hold_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     tgt_q   <= hdr_tgt;
                     addr_q  <= hdr_addr;
                     rem_q   <= hdr_cnt;
                     state_q <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  wr_en_q   <= 1'b1;
                  wr_sel_q  <= tgt_q;
                  wr_addr_q <= addr_q;
                  wr_data_q <= prog_TDATA & DATA_MASK;
                  addr_q    <= addr_q + CODE_ADDR_WIDTH'(1);
                  rem_q     <= rem_q - 14'd1;
                  if (rem_q == 14'd1) begin
                     if (prog_TLAST) begin
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                        state_q <= IDLE;
                     end else begin
                        state_q <= HDR;
                     end
                  end else if (prog_TLAST) begin
                     // A truncated record still writes this last beat.
                     err_q   <= 1'b1;
                     hold_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
               DRAIN: begin
                  if (prog_TLAST) begin
                     err_q   <= 1'b1;
                     hold_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign mem_wr_en   = wr_en_q;
   assign mem_wr_sel  = wr_sel_q;
   assign mem_wr_addr = wr_addr_q;
   assign mem_wr_data = wr_data_q;
   assign hold_in_rst = hold_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_axis_cpu_loader.sv
// -----------------------------------------------------------------------------
// tb_axis_cpu_loader
//   Randomised and directed stimulus for axis_cpu_loader. The bench builds each
//   packet from record descriptions. While building, it attaches to every beat
//   the outputs that beat must cause on the following cycle: the write it
//   produces and how it ends the packet. These expectations are worked out
//   from the record layout alone.
// -----------------------------------------------------------------------------
module tb_axis_cpu_loader;

   localparam int unsigned AW = 10;

   localparam logic [1:0] FIN_NONE = 2'd0;
   localparam logic [1:0] FIN_DONE = 2'd1;
   localparam logic [1:0] FIN_ERR  = 2'd2;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   prog_TDATA;
   logic          prog_TVALID;
   logic          prog_TREADY;
   logic          prog_TLAST;
   logic          mem_wr_en;
   logic [1:0]    mem_wr_sel;
   logic [AW-1:0] mem_wr_addr;
   logic [31:0]   mem_wr_data;
   logic          hold_in_rst;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   axis_cpu_loader #(
      .CODE_ADDR_WIDTH (AW),
      .IMM_WIDTH       (32),
      .JMP_OFF_WIDTH   (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .prog_TDATA  (prog_TDATA),
      .prog_TVALID (prog_TVALID),
      .prog_TREADY (prog_TREADY),
      .prog_TLAST  (prog_TLAST),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_sel  (mem_wr_sel),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .hold_in_rst (hold_in_rst),
      .done        (done),
      .err         (err)
   );

   typedef struct packed {
      logic [31:0]   data;
      logic          last;
      logic          wr;
      logic [1:0]    sel;
      logic [AW-1:0] addr;
      logic [1:0]    fin;
   } beat_t;

   beat_t       pkt[$];
   logic [31:0] pay_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // Expected outputs for the cycle after the current clock edge.
   logic          e_wr, e_done, e_err, e_hold, e_rst;
   logic [1:0]    e_sel;
   logic [AW-1:0] e_addr;
   logic [31:0]   e_data;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] next_pay();
      if (pay_q.size() > 0) return pay_q.pop_front();
      return $urandom();
   endfunction

   function automatic void push(input logic [31:0] d, input logic l, input logic w,
                                input logic [1:0] s, input logic [AW-1:0] a,
                                input logic [1:0] f);
      beat_t b;
      b.data = d; b.last = l; b.wr = w; b.sel = s; b.addr = a; b.fin = f;
      pkt.push_back(b);
   endfunction

   // Appends one record to pkt. The record carries n_send payload beats. If
   // last is set, the record closes the packet. A record that closes the packet
   // with n_send < cnt is truncated.
   function automatic void add_rec(input logic [1:0] tgt, input int unsigned cnt,
                                   input logic [15:0] start, input int unsigned n_send,
                                   input logic last);
      logic [31:0] hdr;
      logic        l;
      hdr = {tgt, 14'(cnt), start};
      if (tgt == 2'd3) begin
         l = last && (n_send == 0);
         push(hdr, l, 1'b0, 2'd0, '0, l ? FIN_ERR : FIN_NONE);
         for (int unsigned i = 0; i < n_send; i++) begin
            l = last && (i == n_send - 1);
            push($urandom(), l, 1'b0, 2'd0, '0, l ? FIN_ERR : FIN_NONE);
         end
      end else if (cnt == 0) begin
         push(hdr, last, 1'b0, 2'd0, '0, last ? FIN_DONE : FIN_NONE);
      end else begin
         l = last && (n_send == 0);
         push(hdr, l, 1'b0, 2'd0, '0, l ? FIN_ERR : FIN_NONE);
         for (int unsigned i = 0; i < n_send; i++) begin
            l = last && (i == n_send - 1);
            push(next_pay(), l, 1'b1, tgt, AW'(32'(start) + i),
                 l ? ((i == cnt - 1) ? FIN_DONE : FIN_ERR) : FIN_NONE);
         end
      end
   endfunction

   // Presents one cycle of input, works out the expected response, and checks
   // it half a cycle after the edge.
   task automatic step(input logic v, input beat_t b);
      prog_TVALID = v;
      prog_TDATA  = v ? b.data : $urandom();
      prog_TLAST  = v ? b.last : 1'($urandom_range(1));
      @(posedge clk);
      e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0; e_rst = rst;
      if (rst) begin
         e_sel = '0; e_addr = '0; e_data = '0; e_hold = 1'b0;
      end else if (v) begin
         if (b.wr) begin
            e_wr = 1'b1; e_sel = b.sel; e_addr = b.addr; e_data = b.data;
         end
         e_done = (b.fin == FIN_DONE);
         e_err  = (b.fin == FIN_ERR);
         e_hold = (b.fin == FIN_NONE);
      end
      @(negedge clk);
      check("tready", 32'(prog_TREADY), 32'(!rst));
      check("wr_en",  32'(mem_wr_en),   32'(e_wr));
      check("done",   32'(done),        32'(e_done));
      check("err",    32'(err),         32'(e_err));
      check("hold",   32'(hold_in_rst), 32'(e_hold));
      if (e_wr || e_rst) begin
         check("wr_sel",  32'(mem_wr_sel),  32'(e_sel));
         check("wr_addr", 32'(mem_wr_addr), 32'(e_addr));
         check("wr_data", mem_wr_data,      e_data);
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, '0);
   endtask

   task automatic drive_pkt(input int unsigned gap_pct);
      beat_t b;
      while (pkt.size() > 0) begin
         b = pkt.pop_front();
         while ($urandom_range(99) < gap_pct) step(1'b0, b);
         step(1'b1, b);
      end
   endtask

   task automatic rand_pkt();
      int unsigned nrec, cnt, n_send;
      logic [1:0]  tgt;
      logic [15:0] start;
      logic        last;
      nrec = $urandom_range(3, 1);
      for (int unsigned r = 0; r < nrec; r++) begin
         last  = (r == nrec - 1);
         tgt   = last ? 2'($urandom_range(3)) : 2'($urandom_range(2));
         cnt   = $urandom_range(5);
         start = 16'($urandom());
         if ($urandom_range(3) == 0) start[9:0] = 10'h3FE | 10'($urandom_range(1));
         n_send = cnt;
         if (tgt == 2'd3) n_send = $urandom_range(3);
         else if (last && cnt > 0 && $urandom_range(3) == 0) n_send = $urandom_range(cnt - 1);
         add_rec(tgt, cnt, start, n_send, last);
      end
   endtask

   initial begin
      rst = 1'b1; prog_TVALID = 1'b0; prog_TDATA = '0; prog_TLAST = 1'b0;
      e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0; e_hold = 1'b0; e_rst = 1'b1;
      e_sel = '0; e_addr = '0; e_data = '0;
      step(1'b1, '0);
      step(1'b1, '0);
      rst = 1'b0;
      idle(2);

      // Single instr record.
      pay_q = '{32'hA1, 32'hB2, 32'hC3};
      add_rec(2'd0, 3, 16'h0005, 3, 1'b1);
      drive_pkt(0);
      idle(2);

      // imm record followed by jmp_off record.
      pay_q = '{32'hDEADBEEF, 32'h7};
      add_rec(2'd1, 1, 16'h0010, 1, 1'b0);
      add_rec(2'd2, 1, 16'h0002, 1, 1'b1);
      drive_pkt(0);
      idle(1);

      // Address wrap.
      add_rec(2'd0, 2, 16'h03FF, 2, 1'b1);
      drive_pkt(0);

      // Truncated record, then a packet decoded from a fresh header.
      add_rec(2'd1, 4, 16'h0100, 2, 1'b1);
      drive_pkt(0);
      add_rec(2'd2, 1, 16'hFC20, 1, 1'b1);
      drive_pkt(0);

      // Reserved target, three junk beats.
      add_rec(2'd3, 0, 16'h0000, 3, 1'b1);
      drive_pkt(0);

      // Empty records: count 0 without TLAST, then count 0 with TLAST.
      add_rec(2'd0, 0, 16'h0000, 0, 1'b0);
      add_rec(2'd1, 0, 16'h0000, 0, 1'b1);
      drive_pkt(0);

      // Header TLAST with a non-zero count.
      add_rec(2'd0, 3, 16'h0001, 0, 1'b1);
      drive_pkt(0);

      // Reset in the middle of a payload, with TVALID held high.
      add_rec(2'd0, 8, 16'h0040, 8, 1'b1);
      for (int k = 0; k < 4; k++) begin
         beat_t b;
         b = pkt.pop_front();
         step(1'b1, b);
      end
      pkt.delete();
      rst = 1'b1;
      step(1'b1, '0);
      step(1'b1, '0);
      rst = 1'b0;
      add_rec(2'd1, 2, 16'h0033, 2, 1'b1);
      drive_pkt(30);

      // Random packets with random gaps.
      for (int p = 0; p < 60; p++) begin
         rand_pkt();
         drive_pkt(25);
         idle($urandom_range(2));
         if (p == 30) begin
            // A second reset, this time during a random packet.
            rand_pkt();
            for (int k = 0; k < 2 && pkt.size() > 0; k++) begin
               beat_t b;
               b = pkt.pop_front();
               step(1'b1, b);
            end
            pkt.delete();
            pay_q.delete();
            rst = 1'b1;
            step(1'b1, '0);
            rst = 1'b0;
         end
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
